sudoku_grid_loader: RTL

//  Consumes uart_byte/byte_ready from the UART receiver and assembles one framed Sudoku puzzle.

---
 rtl/sudoku_grid_loader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sudoku_grid_loader.sv
// sudoku_grid_loader: assembles one framed 81-cell Sudoku puzzle from the UART byte stream.
// Build macro GRID_CHECKSUM_EN adds a trailing XOR checksum byte after the last cell.
module sudoku_grid_loader #(
    parameter int          N_CELLS        = 81,
    parameter logic [7:0]  SYNC_BYTE      = 8'h53,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic                 uart_sampling_clock,
    input  logic                 rst,
    input  logic                 byte_ready,
    input  logic [7:0]           uart_byte,
    input  logic                 grid_ack,
    output logic [4*N_CELLS-1:0] grid,
    output logic                 grid_valid,
    output logic                 loading,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic                 overrun
);

    localparam int               IDX_W       = $clog2(N_CELLS);
    localparam logic [IDX_W-1:0] LAST_CELL   = IDX_W'(N_CELLS - 1);
    localparam logic [19:0]      TIMER_LAST  = TIMEOUT_CYCLES - 20'd1;
    localparam logic [1:0]       ERR_NONE    = 2'b00;
    localparam logic [1:0]       ERR_CHAR    = 2'b01;
    localparam logic [1:0]       ERR_TIMEOUT = 2'b10;

`ifdef GRID_CHECKSUM_EN
    localparam logic [1:0]       ERR_CSUM    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_CHK  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    state_t           state_r;
    logic             ready_q_r;
    logic [IDX_W-1:0] cell_idx_r;
    logic [19:0]      timer_r;
    logic             strobe_s;
    logic             digit_s;
    logic             timeout_s;
`ifdef GRID_CHECKSUM_EN
    logic [7:0]       xor_r;
`endif

    assign strobe_s  = byte_ready & ~ready_q_r;
    assign digit_s   = is_digit(uart_byte);
    assign timeout_s = (timer_r == TIMER_LAST);

    // Frame FSM; every output is a register written only here.
    always_ff @(posedge uart_sampling_clock) begin
        if (rst) begin
            state_r    <= S_IDLE;
            ready_q_r  <= 1'b0;
            cell_idx_r <= '0;
            timer_r    <= 20'd0;
            grid       <= '0;
            grid_valid <= 1'b0;
            loading    <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            overrun    <= 1'b0;
`ifdef GRID_CHECKSUM_EN
            xor_r      <= 8'h00;
`endif
        end else begin
            ready_q_r <= byte_ready;
            error     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (strobe_s && (uart_byte == SYNC_BYTE)) begin
                        state_r    <= S_LOAD;
                        loading    <= 1'b1;
                        cell_idx_r <= '0;
                        timer_r    <= 20'd0;
`ifdef GRID_CHECKSUM_EN
                        xor_r      <= 8'h00;
`endif
                    end
                end
                S_LOAD: begin
                    if (strobe_s) begin
                        if (digit_s) begin
                            // ASCII '0'..'9' carry the cell value in their low nibble.
                            grid[{cell_idx_r, 2'b00} +: 4] <= uart_byte[3:0];
                            timer_r <= 20'd0;
`ifdef GRID_CHECKSUM_EN
                            xor_r   <= xor_r ^ uart_byte;
`endif
                            if (cell_idx_r == LAST_CELL) begin
`ifdef GRID_CHECKSUM_EN
                                state_r    <= S_CHK;
`else
                                state_r    <= S_DONE;
                                grid_valid <= 1'b1;
                                loading    <= 1'b0;
`endif
                            end else begin
                                cell_idx_r <= cell_idx_r + IDX_W'(1);
                            end
                        end else begin
                            state_r  <= S_IDLE;
                            loading  <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_CHAR;
                        end
                    end else if (timeout_s) begin
                        state_r  <= S_IDLE;
                        loading  <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        timer_r <= timer_r + 20'd1;
                    end
                end
`ifdef GRID_CHECKSUM_EN
                S_CHK: begin
                    if (strobe_s) begin
                        loading <= 1'b0;
                        if (uart_byte == xor_r) begin
                            state_r    <= S_DONE;
                            grid_valid <= 1'b1;
                        end else begin
                            state_r  <= S_IDLE;
                            error    <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                    end else if (timeout_s) begin
                        state_r  <= S_IDLE;
                        loading  <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        timer_r <= timer_r + 20'd1;
                    end
                end
`endif
                S_DONE: begin
                    // The grid is frozen here; any byte that arrives is lost.
                    if (strobe_s) begin
                        overrun <= 1'b1;
                    end
                    if (grid_ack) begin
                        state_r    <= S_IDLE;
                        grid_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    grid_valid <= 1'b0;
                    loading    <= 1'b0;
                end
            endcase
        end
    end

endmodule
